// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl: issues MULT operations to a shift-add multiplier and owns the HI/LO registers
module mult_hilo_ctrl #(
    parameter int W       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           Req,
    output logic           Req_Rdy,
    input  logic [W-1:0]   OpA,
    input  logic [W-1:0]   OpB,
    input  logic           RdHi,
    input  logic           RdLo,
    input  logic           WrHi,
    input  logic           WrLo,
    input  logic [W-1:0]   WrData,
    output logic [W-1:0]   RdData,
    output logic           RdValid,
    output logic           Stall,
    output logic           Err,
    output logic           Mult_St,
    output logic [W-1:0]   Mult_A,
    output logic [W-1:0]   Mult_B,
    input  logic           Mult_Idle,
    input  logic           Mult_Done,
    input  logic [2*W-1:0] Mult_Prod
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {SYNC, IDLE, START, WAIT} state_t;
    state_t state, state_nxt;
    logic [W-1:0] hi, lo, pend_a, pend_b;
    logic [CW-1:0] cnt;
    logic pend, accept, issue, timeout, busy, rd, wr;
    assign rd      = RdHi | RdLo;
    assign wr      = WrHi | WrLo;
    assign busy    = (state == START) | (state == WAIT) | pend;
    assign Stall   = (rd | wr) & (busy | (state == SYNC));
    assign Req_Rdy = (state != SYNC) & ~pend;
    assign accept  = Req & Req_Rdy;
    assign Mult_St = (state == START);
    // next-state: a buffered request always wins over a new one when leaving IDLE
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        timeout   = 1'b0;
        case (state)
            SYNC:  state_nxt = Mult_Idle ? IDLE : SYNC;
            IDLE:  begin
                issue     = pend | accept;
                state_nxt = issue ? START : IDLE;
            end
            START: state_nxt = Mult_Idle ? START : WAIT;
            WAIT:  begin
                timeout   = ~Mult_Done & (cnt == CW'(TIMEOUT));
                state_nxt = Mult_Done ? IDLE : (timeout ? SYNC : WAIT);
            end
        endcase
    end
    // state, operand, pending-buffer, HI/LO and read-port registers
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state   <= SYNC;
            hi      <= '0;
            lo      <= '0;
            pend    <= 1'b0;
            pend_a  <= '0;
            pend_b  <= '0;
            RdData  <= '0;
            RdValid <= 1'b0;
            Err     <= 1'b0;
            Mult_A  <= '0;
            Mult_B  <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            RdValid <= rd & ~Stall;
            cnt     <= (state == WAIT) ? cnt + 1'b1 : '0;
            if (rd & ~Stall) RdData <= RdHi ? hi : lo;
            if (issue) begin
                Mult_A <= pend ? pend_a : OpA;
                Mult_B <= pend ? pend_b : OpB;
                pend   <= 1'b0;
            end else if (accept) begin
                pend_a <= OpA;
                pend_b <= OpB;
                pend   <= 1'b1;
            end
            if (WrHi & ~Stall) hi <= WrData;
            if (WrLo & ~Stall) lo <= WrData;
            if ((state == WAIT) & Mult_Done) {hi, lo} <= Mult_Prod;
            if (timeout) Err <= 1'b1;
        end
    end
endmodule
